// File: rtl/cpu_timing_pkg.sv
// Shared T-state / M-cycle timing definitions for the sequencer, microcode blocks and decoder.
package cpu_timing_pkg;

  localparam int unsigned STEP_W  = 4;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    SEQ_RUN   = 2'd0,
    SEQ_STALL = 2'd1,
    SEQ_HALT  = 2'd2
  } seq_state_e;

  localparam logic [STEP_W-1:0]  T1 = 4'b0001;
  localparam logic [STEP_W-1:0]  T2 = 4'b0010;
  localparam logic [STEP_W-1:0]  T3 = 4'b0100;
  localparam logic [STEP_W-1:0]  T4 = 4'b1000;
  localparam logic [COUNT_W-1:0] M1 = 8'h01;

endpackage

// File: rtl/onehot_ring.sv
// One-hot rotating register: hold, rotate left, or restart to bit 0; flags the MSB rotating out.
module onehot_ring #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_shift,
  input  logic             i_restart,
  output logic [WIDTH-1:0] o_ring,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

  logic [WIDTH-1:0] ring_d;
  logic [WIDTH-1:0] ring_q;

  always_comb begin
    ring_d = ring_q;
    if (i_restart) begin
      ring_d = BIT0;
    end else if (i_shift) begin
      ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ring_q <= BIT0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign o_ring = ring_q;
  assign o_wrap = ring_q[WIDTH-1] & i_shift & ~i_restart;

endmodule

// File: rtl/m_cycle_sequencer.sv
// T-state / M-cycle sequencer with fetch latch, bus-stall hold and HALT/wake sequencing.
module m_cycle_sequencer
  import cpu_timing_pkg::*;
#(
  parameter int unsigned STEP_W  = cpu_timing_pkg::STEP_W,
  parameter int unsigned COUNT_W = cpu_timing_pkg::COUNT_W
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_T_En,
  input  logic               i_IR_Fetch,
  input  logic               i_Stall,
  input  logic               i_Halt_Req,
  input  logic               i_Wake,
  output logic [STEP_W-1:0]  o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic               o_Instr_Done,
  output logic               o_Halted,
  output logic               o_Count_Err
);

  seq_state_e state_d, state_q;
  logic       fetch_latch_d, fetch_latch_q;
  logic       instr_done_d, instr_done_q;
  logic       halted_d, halted_q;
  logic       count_err_d, count_err_q;

  logic [STEP_W-1:0]  step;
  logic [COUNT_W-1:0] count;
  logic step_shift, step_wrap;
  logic count_shift, count_restart, count_wrap;
  logic at_boundary, fetch_any, end_instr;

  // A boundary is evaluated on a T4 tick in RUN, or on every tick while stalled at T4.
  // The step ring rotating out of T4 marks the one tick on which the boundary is applied.
  always_comb begin
    at_boundary = i_T_En &&
                  ((state_q == SEQ_RUN && step[STEP_W-1]) || state_q == SEQ_STALL);
    step_shift  = i_T_En && state_q != SEQ_HALT && !(at_boundary && i_Stall);
  end

  assign fetch_any     = fetch_latch_q | i_IR_Fetch;
  assign end_instr     = step_wrap & fetch_any;
  assign count_restart = end_instr;
  assign count_shift   = step_wrap & ~fetch_any;

  always_comb begin
    state_d       = state_q;
    fetch_latch_d = fetch_latch_q;
    instr_done_d  = 1'b0;
    count_err_d   = count_err_q | count_wrap;

    if (i_T_En) begin
      unique case (state_q)
        SEQ_HALT: begin
          if (i_Wake) state_d = SEQ_RUN;
        end
        default: begin
          if (at_boundary && i_Stall) begin
            state_d       = SEQ_STALL;
            fetch_latch_d = fetch_any;
          end else if (end_instr) begin
            fetch_latch_d = 1'b0;
            instr_done_d  = 1'b1;
            state_d       = (i_Halt_Req && !i_Wake) ? SEQ_HALT : SEQ_RUN;
          end else begin
            fetch_latch_d = fetch_any & ~step_wrap;
            state_d       = SEQ_RUN;
          end
        end
      endcase
    end

    halted_d = (state_d == SEQ_HALT);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= SEQ_RUN;
      fetch_latch_q <= 1'b0;
      instr_done_q  <= 1'b0;
      halted_q      <= 1'b0;
      count_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_latch_q <= fetch_latch_d;
      instr_done_q  <= instr_done_d;
      halted_q      <= halted_d;
      count_err_q   <= count_err_d;
    end
  end

  onehot_ring #(.WIDTH(STEP_W)) u_step_ring (
    .i_clk     (i_Clk),
    .i_reset   (i_Reset),
    .i_shift   (step_shift),
    .i_restart (1'b0),
    .o_ring    (step),
    .o_wrap    (step_wrap)
  );

  onehot_ring #(.WIDTH(COUNT_W)) u_count_ring (
    .i_clk     (i_Clk),
    .i_reset   (i_Reset),
    .i_shift   (count_shift),
    .i_restart (count_restart),
    .o_ring    (count),
    .o_wrap    (count_wrap)
  );

  assign o_Cycle_Step  = step;
  assign o_Cycle_Count = count;
  assign o_Instr_Done  = instr_done_q;
  assign o_Halted      = halted_q;
  assign o_Count_Err   = count_err_q;

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Randomized bench for m_cycle_sequencer against an index-based behavioural model.
module tb_m_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst, t_en, ir_fetch, stall, halt_req, wake;
  logic [3:0] step;
  logic [7:0] count;
  logic       instr_done, halted, count_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: T-state index 0..3, M-cycle index 0..7, plus fetch/stall/halt/error flags.
  int t_idx, m_idx;
  bit m_fetch, m_stalled, m_halted, m_err, m_done;

  always #5 clk = ~clk;

  m_cycle_sequencer #(.STEP_W(4), .COUNT_W(8)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_T_En        (t_en),
    .i_IR_Fetch    (ir_fetch),
    .i_Stall       (stall),
    .i_Halt_Req    (halt_req),
    .i_Wake        (wake),
    .o_Cycle_Step  (step),
    .o_Cycle_Count (count),
    .o_Instr_Done  (instr_done),
    .o_Halted      (halted),
    .o_Count_Err   (count_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=0x%0h want=0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_tick();
    bit f_any;
    m_done = 1'b0;
    if (rst) begin
      t_idx = 0; m_idx = 0;
      m_fetch = 0; m_stalled = 0; m_halted = 0; m_err = 0;
    end else if (t_en) begin
      if (m_halted) begin
        if (wake) m_halted = 1'b0;
      end else if (m_stalled || t_idx == 3) begin
        f_any = m_fetch | ir_fetch;
        if (stall) begin
          m_stalled = 1'b1;
          m_fetch   = f_any;
        end else begin
          m_stalled = 1'b0;
          t_idx     = 0;
          if (f_any) begin
            m_idx   = 0;
            m_fetch = 1'b0;
            m_done  = 1'b1;
            if (halt_req && !wake) m_halted = 1'b1;
          end else if (m_idx == 7) begin
            m_idx = 0;
            m_err = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else begin
        t_idx++;
        m_fetch = m_fetch | ir_fetch;
      end
    end
  endtask

  task automatic cycle_and_check();
    logic [3:0] exp_step;
    logic [7:0] exp_count;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    exp_step  = 4'(1 << t_idx);
    exp_count = 8'(1 << m_idx);
    chk("step",  32'(step),       32'(exp_step));
    chk("count", 32'(count),      32'(exp_count));
    chk("done",  32'(instr_done), 32'(m_done));
    chk("halt",  32'(halted),     32'(m_halted));
    chk("err",   32'(count_err),  32'(m_err));
  endtask

  function automatic logic pct(input int unsigned p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic run_phase(input int n, input int unsigned p_ten, input int unsigned p_fetch,
                           input int unsigned p_stall, input int unsigned p_halt,
                           input int unsigned p_wake, input int unsigned p_rst);
    for (int i = 0; i < n; i++) begin
      rst      = pct(p_rst);
      t_en     = pct(p_ten);
      ir_fetch = pct(p_fetch);
      stall    = pct(p_stall);
      halt_req = pct(p_halt);
      wake     = pct(p_wake);
      cycle_and_check();
    end
  endtask

  initial begin
    rst = 1'b1; t_en = 1'b1; ir_fetch = 1'b0; stall = 1'b0; halt_req = 1'b0; wake = 1'b0;
    cycle_and_check();
    cycle_and_check();
    rst = 1'b0;
    // Plain running: fetch on every tick of the last M-cycle would be typical; random here.
    run_phase(400, 100, 10, 0, 0, 0, 0);
    // No fetch at all so the count ring must wrap and raise the sticky error.
    run_phase(80, 100, 0, 0, 0, 0, 0);
    // Error stays sticky across normal operation.
    run_phase(200, 90, 15, 10, 0, 0, 0);
    // Stalls, halts and wakes with gaps in T-state enable.
    run_phase(1500, 75, 15, 30, 50, 10, 0);
    // Halt/wake together frequently.
    run_phase(800, 85, 20, 20, 60, 50, 0);
    // Everything, including resets landing in stall/halt/mid-instruction.
    run_phase(2500, 80, 12, 25, 40, 15, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
